// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU system-bus decoder: FSM states, error causes
// and the default system memory map.
package mmio_pkg;

  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned TO_W    = 8;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_ERR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_RW       = 2'b11
  } err_cause_t;

  // Legacy fixed chip selects: RAM on A15=0, LEDs on A15:12=1001
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_MASK = 16'h8000;
  localparam logic [15:0] LED_BASE = 16'h9000;
  localparam logic [15:0] LED_MASK = 16'hF000;

endpackage

// File: rtl/mmio_decoder_if.sv
// CPU-side bus bundle between the CPU strobes, the decoder and the peripherals.
interface mmio_decoder_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_REGIONS = 4
);

  logic [ADDR_WIDTH-1:0]  address_bus;
  logic                   r;
  logic                   w;
  logic [NUM_REGIONS-1:0] dev_ack;
  logic [NUM_REGIONS-1:0] cs;
  logic                   ready;
  logic                   bus_error;
  logic [ADDR_WIDTH-1:0]  err_addr;
  logic [1:0]             err_cause;

  // CPU and devices drive strobes/acks; the decoder answers
  modport master (
    output address_bus, r, w, dev_ack,
    input  cs, ready, bus_error, err_addr, err_cause
  );

  modport slave (
    input  address_bus, r, w, dev_ack,
    output cs, ready, bus_error, err_addr, err_cause
  );

endinterface

// File: rtl/mmio_region_match.sv
// Combinational address-to-region matcher; lowest-index region wins on overlap.
module mmio_region_match #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned IDX_W       = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit_c,
  output logic [IDX_W-1:0]      idx_c
);

  // Scan from the top so the lowest matching index is the final assignment
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_decoder.sv
// Programmable memory-mapped bus decoder: region chip selects, wait states,
// optional device acknowledge, unmapped/timeout/conflict error reporting.
module mmio_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {16'hF000, 16'hA000, 16'h9000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {16'hF000, 16'hF000, 16'hF000, 16'h8000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT =
    {4'd0, 4'd3, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0] REGION_USE_ACK = 4'b0100,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  mmio_decoder_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic                   ready_q, ready_d;
  logic                   bus_error_q, bus_error_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  err_cause_t             err_cause_q, err_cause_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

  logic                   hit_c;
  logic [IDX_W-1:0]       hit_idx_c;
  logic [WAIT_W-1:0]      hit_wait_c;
  logic                   sel_use_ack_c;
  logic                   sel_ack_c;
  logic                   strobe_c;

  mmio_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_match (
    .addr  (bus.address_bus),
    .hit_c (hit_c),
    .idx_c (hit_idx_c)
  );

  // Per-region attribute lookup with constant part-selects only
  always_comb begin
    hit_wait_c    = '0;
    sel_use_ack_c = 1'b0;
    sel_ack_c     = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit_idx_c == IDX_W'(i)) hit_wait_c = REGION_WAIT[i*WAIT_W +: WAIT_W];
      if (idx_q == IDX_W'(i)) begin
        sel_use_ack_c = REGION_USE_ACK[i];
        sel_ack_c     = bus.dev_ack[i];
      end
    end
  end

  assign strobe_c = bus.r | bus.w;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    ready_d     = 1'b0;
    bus_error_d = 1'b0;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    wait_d      = wait_q;
    to_d        = to_q;
    idx_d       = idx_q;
    addr_d      = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (strobe_c) begin
          addr_d = bus.address_bus;
          if (bus.r && bus.w) begin
            state_d     = ST_ERR;
            ready_d     = 1'b1;
            bus_error_d = 1'b1;
            err_addr_d  = bus.address_bus;
            err_cause_d = ERR_RW;
          end else if (!hit_c) begin
            state_d     = ST_ERR;
            ready_d     = 1'b1;
            bus_error_d = 1'b1;
            err_addr_d  = bus.address_bus;
            err_cause_d = ERR_UNMAPPED;
          end else begin
            state_d = ST_WAIT;
            cs_d    = NUM_REGIONS'(1) << hit_idx_c;
            wait_d  = hit_wait_c;
            to_d    = '0;
            idx_d   = hit_idx_c;
          end
        end
      end

      ST_WAIT: begin
        if (!strobe_c) begin
          state_d = ST_IDLE;
          cs_d    = '0;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (!sel_use_ack_c || sel_ack_c) begin
          state_d = ST_ACK;
          ready_d = 1'b1;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          // Last permitted ack-wait cycle without an acknowledge
          state_d     = ST_ERR;
          cs_d        = '0;
          ready_d     = 1'b1;
          bus_error_d = 1'b1;
          err_addr_d  = addr_q;
          err_cause_d = ERR_TIMEOUT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      ST_ACK: begin
        state_d = ST_DONE;
        cs_d    = '0;
      end

      ST_ERR: begin
        state_d = ST_DONE;
        cs_d    = '0;
      end

      ST_DONE: begin
        cs_d = '0;
        if (!strobe_c) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cs_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cs_q        <= '0;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
      wait_q      <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      ready_q     <= ready_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
      wait_q      <= wait_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.cs        = cs_q;
  assign bus.ready     = ready_q;
  assign bus.bus_error = bus_error_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_cause = err_cause_q;

endmodule

// File: tb/tb_mmio_decoder.sv
// Directed bench for mmio_decoder with the default memory map.
module tb_mmio_decoder;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mmio_decoder_if #(.ADDR_WIDTH(16), .NUM_REGIONS(4)) bus ();

  mmio_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] cs_e,
                            input logic rdy_e, input logic berr_e);
    check({tag, ".cs"},        32'(bus.cs),        32'(cs_e));
    check({tag, ".ready"},     32'(bus.ready),     32'(rdy_e));
    check({tag, ".bus_error"}, 32'(bus.bus_error), 32'(berr_e));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.address_bus = 16'h0000;
    bus.r = 1'b0;
    bus.w = 1'b0;
    bus.dev_ack = 4'b0000;

    // Reset values
    tick();
    tick();
    check_outs("reset", 4'b0000, 1'b0, 1'b0);
    check("reset.err_addr",  32'(bus.err_addr),  32'h0);
    check("reset.err_cause", 32'(bus.err_cause), 32'h0);
    reset = 1'b1;
    tick();

    // RAM read, 0 waits
    bus.address_bus = 16'h0123;
    bus.r = 1'b1;
    tick();
    check_outs("ram.n", 4'b0001, 1'b0, 1'b0);
    tick();
    check_outs("ram.ack", 4'b0001, 1'b1, 1'b0);
    tick();
    check_outs("ram.done", 4'b0000, 1'b0, 1'b0);
    tick();
    check_outs("ram.held", 4'b0000, 1'b0, 1'b0);
    bus.r = 1'b0;
    tick();

    // LED write, 1 wait
    bus.address_bus = 16'h9004;
    bus.w = 1'b1;
    tick();
    check_outs("led.n", 4'b0010, 1'b0, 1'b0);
    tick();
    check_outs("led.wait", 4'b0010, 1'b0, 1'b0);
    tick();
    check_outs("led.ack", 4'b0010, 1'b1, 1'b0);
    tick();
    check_outs("led.done", 4'b0000, 1'b0, 1'b0);
    bus.w = 1'b0;
    tick();

    // Region 2: 3 waits then device acknowledge sampled 6 edges after strobe
    bus.address_bus = 16'hA010;
    bus.r = 1'b1;
    tick();
    check_outs("ack.n", 4'b0100, 1'b0, 1'b0);
    repeat (5) tick();
    check_outs("ack.pending", 4'b0100, 1'b0, 1'b0);
    bus.dev_ack = 4'b0100;
    tick();
    check_outs("ack.ready", 4'b0100, 1'b1, 1'b0);
    bus.dev_ack = 4'b0000;
    tick();
    check_outs("ack.done", 4'b0000, 1'b0, 1'b0);
    bus.r = 1'b0;
    tick();

    // Region 2 with no acknowledge: timeout, address moved after sampling
    bus.address_bus = 16'hA010;
    bus.r = 1'b1;
    tick();
    check_outs("to.n", 4'b0100, 1'b0, 1'b0);
    bus.address_bus = 16'h0000;
    repeat (17) tick();
    check_outs("to.last_wait", 4'b0100, 1'b0, 1'b0);
    tick();
    check_outs("to.err", 4'b0000, 1'b1, 1'b1);
    check("to.err_addr",  32'(bus.err_addr),  32'hA010);
    check("to.err_cause", 32'(bus.err_cause), 32'h2);
    tick();
    check_outs("to.done", 4'b0000, 1'b0, 1'b0);
    check("to.err_addr_held", 32'(bus.err_addr), 32'hA010);
    bus.r = 1'b0;
    tick();

    // Unmapped address
    bus.address_bus = 16'hC000;
    bus.r = 1'b1;
    tick();
    check_outs("unmap.err", 4'b0000, 1'b1, 1'b1);
    check("unmap.err_addr",  32'(bus.err_addr),  32'hC000);
    check("unmap.err_cause", 32'(bus.err_cause), 32'h1);
    tick();
    check_outs("unmap.done", 4'b0000, 1'b0, 1'b0);
    bus.r = 1'b0;
    tick();

    // Read and write together on a mapped address
    bus.address_bus = 16'h0123;
    bus.r = 1'b1;
    bus.w = 1'b1;
    tick();
    check_outs("rw.err", 4'b0000, 1'b1, 1'b1);
    check("rw.err_addr",  32'(bus.err_addr),  32'h0123);
    check("rw.err_cause", 32'(bus.err_cause), 32'h3);
    bus.r = 1'b0;
    bus.w = 1'b0;
    tick();
    tick();

    // Strobe dropped during wait states
    bus.address_bus = 16'hA010;
    bus.r = 1'b1;
    tick();
    check_outs("abort.n", 4'b0100, 1'b0, 1'b0);
    tick();
    bus.r = 1'b0;
    tick();
    check_outs("abort.idle", 4'b0000, 1'b0, 1'b0);
    tick();
    check_outs("abort.quiet", 4'b0000, 1'b0, 1'b0);
    check("abort.err_cause", 32'(bus.err_cause), 32'h3);

    // Asynchronous reset in the middle of a wait
    bus.r = 1'b1;
    tick();
    tick();
    check_outs("rst.wait", 4'b0100, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_outs("rst.async", 4'b0000, 1'b0, 1'b0);
    check("rst.err_addr",  32'(bus.err_addr),  32'h0);
    check("rst.err_cause", 32'(bus.err_cause), 32'h0);
    bus.r = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Fresh access after reset recovery
    bus.address_bus = 16'h7FFF;
    bus.r = 1'b1;
    tick();
    check_outs("post.n", 4'b0001, 1'b0, 1'b0);
    tick();
    check_outs("post.ack", 4'b0001, 1'b1, 1'b0);
    bus.r = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
